// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memory size codes
// (the memory's Digit encoding), the arbiter FSM state type and a helper
// that maps a size code to the number of bytes it touches.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Bytes covered by an access. The illegal code reports 4 so that any
  // range arithmetic stays conservative; legality rejects it separately.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[1:0]    request vector (bit N = port N)
//   advance     arbitration allowed this cycle; gnt is forced to 0 otherwise
//   gnt[1:0]    one-hot grant (combinational)
// The last granted port is remembered; on a tie the other port wins.
// After reset the last owner is port 1, so port 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_owner;

  always_comb begin
    gnt = '0;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_owner ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b1;
    end else if (|gnt) begin
      last_owner <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressable data memory between two requesters
// (port 0 = core load/store unit, port 1 = DMA/test loader).
// Ports:
//   CLK, RST_n            clock, asynchronous active-low reset
//   pN_req/wr/size/addr/wdata   request side, N = 0,1 (req is a level)
//   pN_gnt                1-cycle pulse when the request is latched
//   pN_done/pN_err        1-cycle pulses when the access finishes
//   pN_rdata              zero-extended load data, held until next done
//   mem_wr/size/addr/wdata  memory control (DataWr, Digit, DAddr, DataIn)
//   mem_rdata             memory DataOut, combinational read
// Each granted request is latched and presented to the memory for exactly
// one full clock cycle, so the memory's negedge write lands mid-access.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST_n,

  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [1:0]        p0_size,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,

  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [1:0]        p1_size,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,

  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state;
  logic [1:0]        arb_gnt;
  logic              lat_wr;
  logic              lat_owner;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [ADDR_W:0]   last_byte;
  logic              legal;
  logic [31:0]       load_data;

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst_n   (RST_n),
    .req     ({p1_req, p0_req}),
    .advance (state == IDLE),
    .gnt     (arb_gnt)
  );

  // One extra address bit so that an access running past the top of the
  // address space is seen as out of range instead of wrapping to 0.
  assign last_byte = {1'b0, lat_addr} + (ADDR_W+1)'(nbytes(lat_size))
                   - (ADDR_W+1)'(1);
  assign legal     = (lat_size != SZ_BAD) && (last_byte < MEM_LIMIT);

  // Write enable is decoded from the state, so an asynchronous reset
  // during the access drops it at once and the negedge write never lands.
  assign mem_wr    = lat_wr && legal && (state == ACCESS);
  assign mem_size  = lat_size;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_comb begin
    load_data = '0;
    if (legal) begin
      case (lat_size)
        SZ_BYTE: load_data = {24'b0, mem_rdata[7:0]};
        SZ_HALF: load_data = {16'b0, mem_rdata[15:0]};
        SZ_WORD: load_data = mem_rdata;
        default: load_data = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      lat_wr    <= 1'b0;
      lat_owner <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            state     <= ACCESS;
            lat_owner <= arb_gnt[1];
            lat_wr    <= arb_gnt[1] ? p1_wr    : p0_wr;
            lat_size  <= arb_gnt[1] ? p1_size  : p0_size;
            lat_addr  <= arb_gnt[1] ? p1_addr  : p0_addr;
            lat_wdata <= arb_gnt[1] ? p1_wdata : p0_wdata;
            gnt_q     <= arb_gnt;
          end
        end
        ACCESS: begin
          state             <= IDLE;
          done_q[lat_owner] <= 1'b1;
          err_q[lat_owner]  <= ~legal;
          if (!lat_wr) begin
            if (lat_owner) p1_rdata <= load_data;
            else           p0_rdata <= load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_gnt  = gnt_q[0];
  assign p1_gnt  = gnt_q[1];
  assign p0_done = done_q[0];
  assign p1_done = done_q[1];
  assign p0_err  = err_q[0];
  assign p1_err  = err_q[1];

endmodule
